stw_test_scheduler: RTL and testbench

STW_TEST_SCHEDULER -- requirements
Module: stw_test_scheduler

---
 rtl/stw_test_scheduler.sv | 168 ++++++++++++++++
 tb/tb_stw_test_scheduler.sv | 412 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stw_test_scheduler.sv
// Self-test-while-working scheduler: periodically broadcasts an LFSR test vector,
// starts one PE at a time in round-robin, and records sticky per-PE fault flags.
module stw_test_scheduler #(
    parameter int          WORD_SIZE   = 16,
    parameter int          NUM_PE      = 4,
    parameter int          TEST_PERIOD = 64,
    parameter int          TIMEOUT     = 8,
    parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    input  logic                 stall,
    input  logic                 clear_faults,
    output logic                 stw_test_load_en,
    output logic [WORD_SIZE-1:0] stw_mult_op1,
    output logic [WORD_SIZE-1:0] stw_mult_op2,
    output logic [WORD_SIZE-1:0] stw_add_op,
    output logic [WORD_SIZE-1:0] stw_expected,
    output logic [NUM_PE-1:0]    stw_start,
    input  logic [NUM_PE-1:0]    stw_complete,
    input  logic [NUM_PE-1:0]    stw_result,
    output logic [NUM_PE-1:0]    fault_map,
    output logic                 fault_valid,
    output logic [3:0]           fault_pe_idx,
    output logic                 busy
);

    localparam logic [2:0] S_IDLE        = 3'd0;
    localparam logic [2:0] S_WAIT_PERIOD = 3'd1;
    localparam logic [2:0] S_LOAD        = 3'd2;
    localparam logic [2:0] S_START       = 3'd3;
    localparam logic [2:0] S_WAIT_LOW    = 3'd4;
    localparam logic [2:0] S_WAIT_HIGH   = 3'd5;
    localparam logic [2:0] S_CHECK       = 3'd6;

    localparam int PW = $clog2(TEST_PERIOD + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    logic [2:0]           r_state;
    logic [2:0]           w_next;
    logic [15:0]          r_lfsr;
    logic [15:0]          w_lfsr_next;
    logic [3:0]           r_pe_idx;
    logic [PW-1:0]        r_period;
    logic [TW-1:0]        r_tmo;
    logic                 r_tmo_hit;
    logic                 w_timed_out;
    logic                 w_tmo_expired;
    logic [WORD_SIZE-1:0] r_op1, r_op2, r_add, r_exp;
    logic [WORD_SIZE-1:0] w_op1, w_op2, w_add, w_exp;
    logic [NUM_PE-1:0]    r_fault_map;
    logic                 r_fault_valid;
    logic [3:0]           r_fault_idx;
    logic [NUM_PE-1:0]    w_onehot;
    logic                 w_cur_complete;
    logic                 w_fail;
    logic [NUM_PE-1:0]    w_fail_mask;

    assign w_lfsr_next = {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
    assign w_op1 = r_lfsr;
    assign w_op2 = ~r_lfsr;
    assign w_add = {r_lfsr[7:0], r_lfsr[15:8]};
    assign w_exp = w_op1 * w_op2 + w_add;

    // Mask-and-reduce selects the current PE without an oversized bit index.
    assign w_onehot       = NUM_PE'(1) << r_pe_idx;
    assign w_cur_complete = |(stw_complete & w_onehot);
    assign w_fail         = r_tmo_hit || ~|(stw_result & w_onehot);
    assign w_fail_mask    = (r_state == S_CHECK && w_fail) ? w_onehot : '0;
    assign w_tmo_expired  = (r_tmo == TW'(TIMEOUT - 1));

    always_comb begin
        w_next      = r_state;
        w_timed_out = 1'b0;
        case (r_state)
            S_IDLE:        if (enable) w_next = S_WAIT_PERIOD;
            S_WAIT_PERIOD: begin
                if (!enable)                          w_next = S_IDLE;
                else if (r_period == '0 && !stall)    w_next = S_LOAD;
            end
            S_LOAD:        w_next = S_START;
            S_START:       w_next = S_WAIT_LOW;
            S_WAIT_LOW: begin
                if (w_tmo_expired) begin
                    w_next      = S_CHECK;
                    w_timed_out = 1'b1;
                end else if (!w_cur_complete) begin
                    w_next = S_WAIT_HIGH;
                end
            end
            S_WAIT_HIGH: begin
                if (w_cur_complete) begin
                    w_next = S_CHECK;
                end else if (w_tmo_expired) begin
                    w_next      = S_CHECK;
                    w_timed_out = 1'b1;
                end
            end
            S_CHECK:       w_next = enable ? S_WAIT_PERIOD : S_IDLE;
            default:       w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_lfsr        <= LFSR_SEED;
            r_pe_idx      <= '0;
            r_period      <= '0;
            r_tmo         <= '0;
            r_tmo_hit     <= 1'b0;
            r_op1         <= '0;
            r_op2         <= '0;
            r_add         <= '0;
            r_exp         <= '0;
            r_fault_map   <= '0;
            r_fault_valid <= 1'b0;
            r_fault_idx   <= '0;
        end else begin
            r_state       <= w_next;
            r_fault_valid <= 1'b0;
            // A failure in the same cycle as clear_faults keeps its bit set.
            r_fault_map   <= (clear_faults ? '0 : r_fault_map) | w_fail_mask;
            if (w_next == S_LOAD && r_state == S_WAIT_PERIOD) begin
                r_op1 <= w_op1;
                r_op2 <= w_op2;
                r_add <= w_add;
                r_exp <= w_exp;
            end
            case (r_state)
                S_IDLE: if (enable) r_period <= PW'(TEST_PERIOD);
                S_WAIT_PERIOD: if (r_period != '0) r_period <= r_period - PW'(1);
                S_START: begin
                    r_tmo     <= '0;
                    r_tmo_hit <= 1'b0;
                end
                S_WAIT_LOW, S_WAIT_HIGH: begin
                    r_tmo <= r_tmo + TW'(1);
                    if (w_timed_out) r_tmo_hit <= 1'b1;
                end
                S_CHECK: begin
                    r_lfsr   <= w_lfsr_next;
                    r_pe_idx <= (r_pe_idx == 4'(NUM_PE - 1)) ? '0 : r_pe_idx + 4'(1);
                    if (enable) r_period <= PW'(TEST_PERIOD);
                    if (w_fail) begin
                        r_fault_valid <= 1'b1;
                        r_fault_idx   <= r_pe_idx;
                    end
                end
                default: ;
            endcase
        end
    end

    assign stw_test_load_en = (r_state == S_LOAD);
    assign stw_start        = (r_state == S_START) ? w_onehot : '0;
    assign busy             = (r_state == S_LOAD) || (r_state == S_START) || (r_state == S_WAIT_LOW) ||
                              (r_state == S_WAIT_HIGH) || (r_state == S_CHECK);
    assign stw_mult_op1     = r_op1;
    assign stw_mult_op2     = r_op2;
    assign stw_add_op       = r_add;
    assign stw_expected     = r_exp;
    assign fault_map        = r_fault_map;
    assign fault_valid      = r_fault_valid;
    assign fault_pe_idx     = r_fault_idx;

endmodule

// File: tb/tb_stw_test_scheduler.sv
// Bench for stw_test_scheduler: behavioural PE array plus a test-sequence reference model.
module tb_stw_test_scheduler;

    localparam int NUM_PE      = 4;
    localparam int TEST_PERIOD = 8;
    localparam int TIMEOUT     = 8;

    logic              clk = 1'b0;
    logic              rst, enable, stall, clear_faults;
    logic              stw_test_load_en;
    logic [15:0]       stw_mult_op1, stw_mult_op2, stw_add_op, stw_expected;
    logic [NUM_PE-1:0] stw_start, stw_complete, stw_result, fault_map;
    logic              fault_valid, busy;
    logic [3:0]        fault_pe_idx;

    stw_test_scheduler #(
        .WORD_SIZE(16), .NUM_PE(NUM_PE), .TEST_PERIOD(TEST_PERIOD),
        .TIMEOUT(TIMEOUT), .LFSR_SEED(16'hACE1)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable), .stall(stall), .clear_faults(clear_faults),
        .stw_test_load_en(stw_test_load_en), .stw_mult_op1(stw_mult_op1),
        .stw_mult_op2(stw_mult_op2), .stw_add_op(stw_add_op), .stw_expected(stw_expected),
        .stw_start(stw_start), .stw_complete(stw_complete), .stw_result(stw_result),
        .fault_map(fault_map), .fault_valid(fault_valid), .fault_pe_idx(fault_pe_idx),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // PE behaviour: 0 healthy, 1 wrong result, 2 never drops complete, 3 never raises it again
    int pe_mode [NUM_PE];
    int pe_cnt  [NUM_PE];

    always @(posedge clk) begin
        if (rst) begin
            stw_complete <= '1;
            stw_result   <= '0;
            for (int i = 0; i < NUM_PE; i++) pe_cnt[i] <= 0;
        end else begin
            for (int i = 0; i < NUM_PE; i++) begin
                if (stw_start[i]) begin
                    if (pe_mode[i] != 2) begin
                        stw_complete[i] <= 1'b0;
                        pe_cnt[i]       <= $urandom_range(1, 4);
                    end
                end else if (!stw_complete[i] && pe_mode[i] != 3) begin
                    if (pe_cnt[i] <= 1) begin
                        stw_complete[i] <= 1'b1;
                        stw_result[i]   <= (pe_mode[i] == 0);
                    end else begin
                        pe_cnt[i] <= pe_cnt[i] - 1;
                    end
                end
            end
        end
    end

    // Reference model: sequence number state only
    logic [15:0]       m_lfsr;
    int                m_idx;
    logic [NUM_PE-1:0] m_map;

    function automatic logic [15:0] m_step(input logic [15:0] l);
        return {l[14:0], ^(l & 16'hB400)};
    endfunction

    function automatic logic [15:0] m_expect(input logic [15:0] l);
        int unsigned a, b, c;
        a = l;
        b = 32'd65535 - a;
        c = (a % 256) * 256 + (a / 256);
        return 16'((a * b + c) % 32'd65536);
    endfunction

    function automatic bit m_fails(input int idx);
        return pe_mode[idx] != 0;
    endfunction

    task automatic m_reset();
        m_lfsr = 16'hACE1;
        m_idx  = 0;
        m_map  = '0;
    endtask

    task automatic m_advance();
        if (m_fails(m_idx)) m_map[m_idx] = 1'b1;
        m_lfsr = m_step(m_lfsr);
        m_idx  = (m_idx + 1) % NUM_PE;
    endtask

    // Captured observations of one test
    bit                c_to;
    logic [15:0]       c_op1, c_op2, c_add, c_exp;
    logic [NUM_PE-1:0] c_start, c_fm;
    logic              c_fv, c_fv2;
    logic [3:0]        c_fi;
    int                c_lat;

    task automatic capture(input int stall_cyc);
        int n;
        c_to  = 1'b0;
        n     = 0;
        stall = (stall_cyc > 0);
        while (stw_test_load_en !== 1'b1 && n < 400) begin
            @(negedge clk);
            n++;
            if (n >= stall_cyc) stall = 1'b0;
        end
        if (n >= 400) c_to = 1'b1;
        c_op1 = stw_mult_op1; c_op2 = stw_mult_op2; c_add = stw_add_op; c_exp = stw_expected;
        n = 0;
        while (stw_start === '0 && n < 10) begin @(negedge clk); n++; end
        if (n >= 10) c_to = 1'b1;
        c_start = stw_start;
        n = 0;
        while (busy !== 1'b0 && n < 60) begin @(negedge clk); n++; end
        if (n >= 60) c_to = 1'b1;
        c_lat = n;
        c_fv  = fault_valid; c_fi = fault_pe_idx; c_fm = fault_map;
        @(negedge clk);
        c_fv2 = fault_valid;
    endtask

    task automatic do_reset();
        rst = 1'b1; enable = 1'b0; stall = 1'b0; clear_faults = 1'b0;
        for (int i = 0; i < NUM_PE; i++) pe_mode[i] = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        m_reset();
    endtask

    task automatic test_reset();
        rst = 1'b1; enable = 1'b0; stall = 1'b0; clear_faults = 1'b0;
        for (int i = 0; i < NUM_PE; i++) pe_mode[i] = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        total++;
        if ({stw_test_load_en, stw_start, busy, fault_valid, fault_pe_idx, fault_map} !== '0) begin
            bad++;
            $display("FAIL reset_ctrl: got load=%b start=%b busy=%b fv=%b fi=%0d fm=%b, want all 0",
                     stw_test_load_en, stw_start, busy, fault_valid, fault_pe_idx, fault_map);
        end
        total++;
        if ({stw_mult_op1, stw_mult_op2, stw_add_op, stw_expected} !== 64'd0) begin
            bad++;
            $display("FAIL reset_vec: got %h %h %h %h, want 0", stw_mult_op1, stw_mult_op2, stw_add_op, stw_expected);
        end
        rst = 1'b0;
        m_reset();
    endtask

    task automatic test_first_vector();
        enable = 1'b1;
        capture(0);
        total++;
        if (c_to) begin bad++; $display("FAIL first_timeout: got timeout, want test completion"); end
        total++;
        if ({c_op1, c_op2, c_add, c_exp} !== {16'hACE1, 16'h531E, 16'hE1AC, 16'h170A}) begin
            bad++;
            $display("FAIL first_vector: got %h %h %h %h, want ACE1 531E E1AC 170A", c_op1, c_op2, c_add, c_exp);
        end
        total++;
        if (c_start !== 4'b0001) begin bad++; $display("FAIL first_start: got %b, want 0001", c_start); end
        total++;
        if ({c_fv, c_fv2, c_fm} !== '0) begin
            bad++;
            $display("FAIL first_nofault: got fv=%b/%b fm=%b, want 0", c_fv, c_fv2, c_fm);
        end
        m_advance();
    endtask

    task automatic test_rotation();
        logic [NUM_PE-1:0] want;
        for (int t = 0; t < 4; t++) begin
            capture(0);
            want = NUM_PE'(1) << m_idx;
            total++;
            if (c_to || c_start !== want) begin
                bad++;
                $display("FAIL rotation_start[%0d]: got %b to=%0d, want %b", t, c_start, c_to, want);
            end
            total++;
            if (c_op1 !== m_lfsr || c_exp !== m_expect(m_lfsr)) begin
                bad++;
                $display("FAIL rotation_vec[%0d]: got op1=%h exp=%h, want %h %h", t, c_op1, c_exp, m_lfsr, m_expect(m_lfsr));
            end
            m_advance();
        end
    endtask

    task automatic test_bad_result();
        do_reset();
        pe_mode[2] = 1;
        enable = 1'b1;
        for (int t = 0; t < 3; t++) begin
            capture(0);
            total++;
            if (c_to || c_fv !== m_fails(m_idx)) begin
                bad++;
                $display("FAIL badres_fv[%0d]: got fv=%b to=%0d, want %b", t, c_fv, c_to, m_fails(m_idx));
            end
            m_advance();
        end
        total++;
        if (c_fm !== 4'b0100 || c_fi !== 4'd2 || c_fv2 !== 1'b0) begin
            bad++;
            $display("FAIL badres_map: got fm=%b fi=%0d fv_next=%b, want 0100 2 0", c_fm, c_fi, c_fv2);
        end
    endtask

    task automatic test_hang();
        do_reset();
        pe_mode[1] = 2;
        enable = 1'b1;
        capture(0);
        m_advance();
        capture(0);
        total++;
        if (c_to || c_fm !== 4'b0010 || c_fi !== 4'd1 || c_fv !== 1'b1) begin
            bad++;
            $display("FAIL hang_fault: got fm=%b fi=%0d fv=%b to=%0d, want 0010 1 1", c_fm, c_fi, c_fv, c_to);
        end
        total++;
        if (c_lat < TIMEOUT || c_lat > TIMEOUT + 2) begin
            bad++;
            $display("FAIL hang_latency: got %0d cycles, want %0d..%0d", c_lat, TIMEOUT, TIMEOUT + 2);
        end
        m_advance();
        capture(0);
        total++;
        if (c_start !== 4'b0100) begin bad++; $display("FAIL hang_next: got %b, want 0100", c_start); end
        m_advance();
    endtask

    task automatic test_repeat_failure();
        int pulses;
        do_reset();
        pe_mode[0] = 1;
        enable = 1'b1;
        pulses = 0;
        for (int t = 0; t < 5; t++) begin
            capture(0);
            if (c_fv === 1'b1) begin
                pulses++;
                total++;
                if (c_fi !== 4'd0) begin bad++; $display("FAIL repeat_idx[%0d]: got %0d, want 0", t, c_fi); end
            end
            m_advance();
        end
        total++;
        if (pulses != 2) begin bad++; $display("FAIL repeat_pulses: got %0d, want 2", pulses); end
    endtask

    task automatic test_clear_faults();
        // continues after test_repeat_failure: fault_map=0001, next PE is 1
        pe_mode[0] = 0;
        pe_mode[1] = 1;
        clear_faults = 1'b1;
        capture(0);
        clear_faults = 1'b0;
        m_map = '0;
        m_advance();
        total++;
        if (c_fm !== 4'b0010 || c_fv !== 1'b1) begin
            bad++;
            $display("FAIL clear_same_cycle: got fm=%b fv=%b, want 0010 1", c_fm, c_fv);
        end
        capture(0);
        m_advance();
        @(negedge clk);
        clear_faults = 1'b1;
        @(negedge clk);
        clear_faults = 1'b0;
        m_map = '0;
        total++;
        if (fault_map !== '0) begin bad++; $display("FAIL clear_idle: got %b, want 0000", fault_map); end
    endtask

    task automatic test_stall();
        int seen;
        do_reset();
        stall  = 1'b1;
        enable = 1'b1;
        seen = 0;
        repeat (TEST_PERIOD + 6) begin
            @(negedge clk);
            if (stw_test_load_en === 1'b1) seen++;
        end
        total++;
        if (seen != 0) begin bad++; $display("FAIL stall_hold: got %0d loads, want 0", seen); end
        stall = 1'b0;
        @(negedge clk);
        total++;
        if (stw_test_load_en !== 1'b1 || stw_mult_op1 !== 16'hACE1) begin
            bad++;
            $display("FAIL stall_release: got load=%b op1=%h, want 1 ACE1", stw_test_load_en, stw_mult_op1);
        end
        seen = 0;
        while (busy !== 1'b0 && seen < 60) begin @(negedge clk); seen++; end
        @(negedge clk);
        m_advance();
    endtask

    task automatic test_enable_drop();
        int n, seen;
        // continues after test_stall: model points at PE1
        capture(0);
        m_advance();
        n = 0;
        while (stw_start === '0 && n < 400) begin @(negedge clk); n++; end
        @(negedge clk);
        enable = 1'b0;
        n = 0;
        while (busy !== 1'b0 && n < 60) begin @(negedge clk); n++; end
        total++;
        if (n >= 60 || fault_valid !== 1'b0) begin
            bad++;
            $display("FAIL endrop_finish: got wait=%0d fv=%b, want completion without fault", n, fault_valid);
        end
        m_advance();
        seen = 0;
        repeat (3 * TEST_PERIOD) begin
            @(negedge clk);
            if (stw_test_load_en === 1'b1 || busy === 1'b1) seen++;
        end
        total++;
        if (seen != 0) begin bad++; $display("FAIL endrop_idle: got %0d active cycles, want 0", seen); end
        enable = 1'b1;
        capture(0);
        total++;
        if (c_start !== 4'b1000) begin bad++; $display("FAIL endrop_next: got %b, want 1000", c_start); end
        m_advance();
    endtask

    task automatic test_random();
        logic [NUM_PE-1:0] want;
        do_reset();
        for (int i = 0; i < NUM_PE; i++) pe_mode[i] = $urandom_range(0, 3);
        enable = 1'b1;
        for (int t = 0; t < 12; t++) begin
            capture($urandom_range(0, 15));
            want = NUM_PE'(1) << m_idx;
            total++;
            if (c_to || c_start !== want) begin
                bad++;
                $display("FAIL rand_start[%0d]: got %b to=%0d, want %b", t, c_start, c_to, want);
            end
            total++;
            if ({c_op1, c_op2, c_add, c_exp} !== {m_lfsr, ~m_lfsr, m_lfsr[7:0], m_lfsr[15:8], m_expect(m_lfsr)}) begin
                bad++;
                $display("FAIL rand_vec[%0d]: got %h %h %h %h, lfsr want %h exp %h", t, c_op1, c_op2, c_add, c_exp,
                         m_lfsr, m_expect(m_lfsr));
            end
            total++;
            if (c_fv !== m_fails(m_idx) || (c_fv === 1'b1 && c_fi !== 4'(m_idx))) begin
                bad++;
                $display("FAIL rand_fault[%0d]: got fv=%b fi=%0d, want %b %0d", t, c_fv, c_fi, m_fails(m_idx), m_idx);
            end
            m_advance();
            total++;
            if (c_fm !== m_map) begin bad++; $display("FAIL rand_map[%0d]: got %b, want %b", t, c_fm, m_map); end
        end
    endtask

    task automatic test_midreset();
        int n;
        enable = 1'b1;
        n = 0;
        while (stw_start === '0 && n < 400) begin @(negedge clk); n++; end
        #2 rst = 1'b1;
        #1;
        total++;
        if (n >= 400 || stw_start !== '0 || stw_test_load_en !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL midreset_async: got start=%b load=%b busy=%b, want 0", stw_start, stw_test_load_en, busy);
        end
        enable = 1'b0;
        for (int i = 0; i < NUM_PE; i++) pe_mode[i] = 0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        m_reset();
        enable = 1'b1;
        capture(0);
        total++;
        if (c_start !== 4'b0001 || c_op1 !== 16'hACE1 || c_fm !== '0) begin
            bad++;
            $display("FAIL midreset_restart: got start=%b op1=%h fm=%b, want 0001 ACE1 0000", c_start, c_op1, c_fm);
        end
    endtask

    initial begin
        test_reset();
        test_first_vector();
        test_rotation();
        test_bad_result();
        test_hang();
        test_repeat_failure();
        test_clear_faults();
        test_stall();
        test_enable_drop();
        test_random();
        test_midreset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
